obi_pipeline_cut: RTL and testbench
===================================

# obi_pipeline_cut

Timing cut on one OBI link. It sits between any OBI master (core instruction/data port, DMA) and the bus or slave it drives, and consumes the request/response structs from `obi_pkg`. Requests are buffered in a small registered FIFO, so no combinational path runs from the downstream `gnt` to the upstream `gnt`. The number of in-flight transactions is bounded, and responses are returned in order.

## Interface
- `DEPTH`, default 2: request FIFO entries. Must be a power of two, 2..8.
- `MAX_OUTSTANDING`, default 4: maximum accepted-but-unanswered transactions. Must be at least `DEPTH`, at most 15.
- `clk_i`, input, 1: the single clock.
- `rst_ni`, input, 1: reset. Asynchronous, active-low.
- `up_req_i`, input, `obi_req_t`: request from the upstream master.
- `up_resp_o`, output, `obi_resp_t`: `gnt`/`rvalid`/`rdata` returned to the upstream master.
- `dn_req_o`, output, `obi_req_t`: request to the downstream slave or bus.
- `dn_resp_i`, input, `obi_resp_t`: response from the downstream slave.
- `outstanding_o`, output, 4: current in-flight count, for debug and verification.

## Operation
- Upstream accept occurs in a cycle with `up_req_i.req && up_resp_o.gnt`.
  - The full `we`/`be`/`addr`/`wdata` word is pushed into the FIFO at the tail.
- `up_resp_o.gnt = up_req_i.req && !full_q && (outstanding_q < MAX_OUTSTANDING)`.
  - `full_q` and `outstanding_q` are registers only. `dn_resp_i` has no combinational influence on `gnt`.
- `dn_req_o.req = !empty_q`. The other `dn_req_o` fields are taken from the FIFO head.
  - While `dn_req_o.req` is low, `dn_req_o` fields are 0.
- Downstream handshake: a cycle with `dn_req_o.req && dn_resp_i.gnt` pops the head.
  - The head stays stable until it is granted, as OBI requires.
- There is no bypass: an empty FIFO never forwards `up_req_i` in the same cycle.
- Push and pop in the same cycle are allowed whenever the FIFO is not full.
  - Pointers advance independently and wrap modulo `DEPTH`.
  - The occupancy count is unchanged in that cycle.
- When the FIFO is full, `gnt` is low even if a pop happens that cycle. The freed slot is usable next cycle.
- Outstanding counter:
  - Increments on an upstream accept.
  - Decrements when a response is delivered upstream (`up_resp_o.rvalid`).
  - Both in one cycle give a net change of 0.
  - The counter never exceeds `MAX_OUTSTANDING` and never underflows.
- Stray response: a downstream `rvalid` arriving while `outstanding_q == 0` is dropped and not forwarded.
- The downstream slave is required to answer in order. This block does no reordering and keeps no IDs.
- `rdata` is forwarded unchanged. It is meaningful only when `rvalid` is high and is 0 otherwise.

## Timing
- Reset state:
  - All outputs are 0.
  - FIFO is empty, pointers are 0, `outstanding_q` is 0.
  - Response register is cleared.
- Reset asserted mid-operation:
  - Buffered requests and the outstanding count are discarded asynchronously.
  - Responses for discarded requests arriving after reset are treated as stray and dropped.
- Request latency: a request accepted in cycle N appears on `dn_req_o` in cycle N+1 at the earliest.
- Throughput: one request per cycle sustained when `DEPTH >= 2` and the downstream grants every cycle.
- Response latency:
  - Without the Configuration macro: 0 cycles, combinational passthrough.
  - With the macro: 1 cycle (see Configuration).
- `gnt` is issued in the same cycle as `up_req_i.req` when space is available, and depends only on `up_req_i.req` plus registers.

## Configuration
- Macro: `OBI_PIPELINE_CUT_RSP_REG_EN`.
- Defined:
  - `dn_resp_i.rvalid`/`rdata` are registered.
  - `up_resp_o.rvalid` is high exactly one cycle after the downstream `rvalid`.
  - The counter decrement happens on the registered `rvalid`.
  - A fully registered path results in both directions.
- Undefined:
  - `up_resp_o.rvalid = dn_resp_i.rvalid && (outstanding_q != 0)`.
  - `rdata` is passed through combinationally.
- No response backpressure is needed in either mode, since OBI has no `rready`.

## Structure
- `obi_req_t` and `obi_resp_t` come from `obi_pkg`.
  - Add to `obi_pkg` the payload typedef `obi_req_payload_t` (`we`, `be`, `addr`, `wdata`, without `req`).
  - This typedef is the FIFO storage width and is reusable by other OBI buffers.
- Sub-module: `obi_pipeline_cut_fifo`.
  - Generic payload FIFO with `DEPTH`, push/pop, and registered `full`/`empty`.
  - Owns the pointers and the occupancy counter.
- The top level holds the gnt logic, the outstanding counter and the optional response register.

## Test plan
- Single read: accept `addr=0x1000` in cycle 0, downstream grants in cycle 1, `rvalid` with `rdata=0xDEADBEEF` in cycle 3.
  - Upstream sees `rvalid` and `0xDEADBEEF` in cycle 3, or cycle 4 with the macro.
  - `outstanding_o` reads 1, then 0.
- Backpressure with `DEPTH=2`: downstream `gnt` held low, upstream `req` held high.
  - Two accepts, then `gnt` stays low.
  - `dn_req_o` head stays stable with the first address.
  - Releasing the downstream grant drains the requests in order.
- Outstanding limit with `MAX_OUTSTANDING=4`: downstream grants instantly but never responds.
  - Exactly 4 accepts, then `gnt` stays low.
  - One response lets `gnt` return on the next cycle.
- Back-to-back stream: 16 writes with `be=0xF` and downstream grant/response every cycle.
  - 16 accepts occur in 16 consecutive cycles.
  - `dn_req_o` carries the same addresses and `wdata` in order.
- Reset mid-burst: `rst_ni` pulsed low with 2 entries buffered and 3 outstanding.
  - All outputs are 0 immediately.
  - A later downstream `rvalid` is not forwarded.
- Push/pop same cycle at occupancy 1 over 20 cycles: occupancy stays 1, pointers wrap correctly, and data stays ordered.

Source files
------------

// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI request/response structs shared by OBI masters, slaves and buffers
package obi_pkg;

    localparam int unsigned OBI_AW  = 32;
    localparam int unsigned OBI_DW  = 32;
    localparam int unsigned OBI_BEW = OBI_DW / 8;

    typedef struct packed {
        logic               req;
        logic               we;
        logic [OBI_BEW-1:0] be;
        logic [OBI_AW-1:0]  addr;
        logic [OBI_DW-1:0]  wdata;
    } obi_req_t;

    typedef struct packed {
        logic              gnt;
        logic              rvalid;
        logic [OBI_DW-1:0] rdata;
    } obi_resp_t;

    // Request word without the handshake bit; the storage element of OBI request buffers.
    typedef struct packed {
        logic               we;
        logic [OBI_BEW-1:0] be;
        logic [OBI_AW-1:0]  addr;
        logic [OBI_DW-1:0]  wdata;
    } obi_req_payload_t;

    function automatic obi_req_payload_t obi_payload_of(obi_req_t r);
        obi_req_payload_t p;
        p.we    = r.we;
        p.be    = r.be;
        p.addr  = r.addr;
        p.wdata = r.wdata;
        return p;
    endfunction

endpackage

// File: rtl/obi_pipeline_cut_fifo.sv
// rtl/obi_pipeline_cut_fifo.sv - registered OBI payload FIFO with registered full/empty
module obi_pipeline_cut_fifo
    import obi_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  obi_req_payload_t push_data_i,
    input  logic             pop_i,
    output obi_req_payload_t head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    obi_req_payload_t mem_q [DEPTH];
    obi_req_payload_t mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses pushes even if it pops this cycle; an empty one never pops.
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    // Next-state: write at tail, advance pointers (power-of-two depth wraps naturally), track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == CNT_W'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    // State registers; reset discards all buffered words.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/obi_pipeline_cut.sv
// rtl/obi_pipeline_cut.sv - OBI timing cut, optional response register via OBI_PIPELINE_CUT_RSP_REG_EN
module obi_pipeline_cut
    import obi_pkg::*;
#(
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  obi_req_t   up_req_i,
    output obi_resp_t  up_resp_o,
    output obi_req_t   dn_req_o,
    input  obi_resp_t  dn_resp_i,
    output logic [3:0] outstanding_o
);

    logic [3:0]        outstanding_q, outstanding_d;
    logic              fifo_full;
    logic              fifo_empty;
    obi_req_payload_t  fifo_head;
    logic              up_gnt;
    logic              dn_pop;
    logic              up_rvalid;
    logic [OBI_DW-1:0] up_rdata;

    // Grant uses only the upstream req and registers; reset forces it low so every output is 0.
    assign up_gnt = rst_ni && up_req_i.req && !fifo_full && (outstanding_q < 4'(MAX_OUTSTANDING));
    assign dn_pop = !fifo_empty && dn_resp_i.gnt;

    obi_pipeline_cut_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (up_gnt),
        .push_data_i (obi_payload_of(up_req_i)),
        .pop_i       (dn_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef OBI_PIPELINE_CUT_RSP_REG_EN
    logic              rsp_valid_q, rsp_valid_d;
    logic [OBI_DW-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]        pending;

    // A response already sitting in the register still counts as outstanding, so exclude it
    // when deciding whether the incoming one is stray.
    assign pending = outstanding_q - {3'b000, rsp_valid_q};

    // Capture the next downstream response unless it has no matching request.
    always_comb begin
        rsp_valid_d = dn_resp_i.rvalid && (pending != 4'd0);
        rsp_data_d  = rsp_valid_d ? dn_resp_i.rdata : '0;
    end

    // Response register: one cycle of response latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign up_rvalid = rsp_valid_q;
    assign up_rdata  = rsp_data_q;
`else
    assign up_rvalid = dn_resp_i.rvalid && (outstanding_q != 4'd0);
    assign up_rdata  = up_rvalid ? dn_resp_i.rdata : '0;
`endif

    // In-flight count: up on accept, down on delivered response, unchanged when both.
    always_comb begin
        case ({up_gnt, up_rvalid})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Outstanding counter register; reset forgets every in-flight transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= 4'd0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    // Output assembly: downstream fields are zeroed while no request is presented.
    always_comb begin
        dn_req_o     = '0;
        dn_req_o.req = !fifo_empty;
        if (!fifo_empty) begin
            dn_req_o.we    = fifo_head.we;
            dn_req_o.be    = fifo_head.be;
            dn_req_o.addr  = fifo_head.addr;
            dn_req_o.wdata = fifo_head.wdata;
        end
        up_resp_o        = '0;
        up_resp_o.gnt    = up_gnt;
        up_resp_o.rvalid = up_rvalid;
        up_resp_o.rdata  = up_rdata;
    end

    assign outstanding_o = outstanding_q;

endmodule

// File: tb/tb_obi_pipeline_cut.sv
// tb/tb_obi_pipeline_cut.sv - scoreboard bench for obi_pipeline_cut
module tb_obi_pipeline_cut;
    import obi_pkg::*;

`ifdef OBI_PIPELINE_CUT_RSP_REG_EN
    localparam int RSP_LAT = 1;
`else
    localparam int RSP_LAT = 0;
`endif
    localparam int BIG = 32'h7fff_ffff;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    obi_req_t   up_req_i;
    obi_resp_t  up_resp_o;
    obi_req_t   dn_req_o;
    obi_resp_t  dn_resp_i;
    logic [3:0] outstanding_o;

    bit         manual = 1'b1;
    obi_resp_t  man_resp;
    obi_resp_t  slv_resp;
    bit         slv_gnt;
    int         slv_budget;
    int         slv_used = 0;
    bit         hs_valid = 1'b0;
    logic [31:0] hs_addr;

    int n_vec = 0;
    int n_err = 0;

    obi_req_payload_t exp_req_q [$];
    logic [31:0]      exp_rsp_q [$];
    logic [31:0]      pend_q    [$];
    obi_req_payload_t mon_e;

    always #5 clk_i = ~clk_i;

    assign dn_resp_i = manual ? man_resp : slv_resp;

    obi_pipeline_cut #(
        .DEPTH           (2),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .up_req_i      (up_req_i),
        .up_resp_o     (up_resp_o),
        .dn_req_o      (dn_req_o),
        .dn_resp_i     (dn_resp_i),
        .outstanding_o (outstanding_o)
    );

    function automatic logic [31:0] data_of(logic [31:0] a);
        return (a == 32'h1000) ? 32'hDEAD_BEEF : ~a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk_i);
            done = (outstanding_o == 4'd0) && !dn_req_o.req && (exp_rsp_q.size() == 0);
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    // Monitor: records accepts as expectations, checks downstream handshakes and upstream responses.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            exp_req_q.delete();
            exp_rsp_q.delete();
            hs_valid = 1'b0;
        end else begin
            if (up_req_i.req && up_resp_o.gnt) begin
                exp_req_q.push_back(obi_payload_of(up_req_i));
                exp_rsp_q.push_back(data_of(up_req_i.addr));
            end
            hs_valid = dn_req_o.req && dn_resp_i.gnt;
            hs_addr  = dn_req_o.addr;
            if (hs_valid) begin
                if (exp_req_q.size() == 0) begin
                    chk("dn_unexpected_req", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_req_q.pop_front();
                    chk("dn_addr", dn_req_o.addr, mon_e.addr);
                    chk("dn_wdata", dn_req_o.wdata, mon_e.wdata);
                    chk("dn_we_be", {27'd0, dn_req_o.we, dn_req_o.be}, {27'd0, mon_e.we, mon_e.be});
                end
            end
            if (!dn_req_o.req) chk("dn_idle_zero", 32'(|dn_req_o), 32'd0);
            if (up_resp_o.rvalid) begin
                if (exp_rsp_q.size() == 0) chk("up_stray_rvalid", 32'd1, 32'd0);
                else chk("up_rdata", up_resp_o.rdata, exp_rsp_q.pop_front());
            end else begin
                chk("up_rdata_idle", up_resp_o.rdata, 32'd0);
            end
        end
    end

    // Downstream slave model: grants per slv_gnt, answers granted requests in order one cycle later.
    always @(posedge clk_i) begin
        #1;
        if (!rst_ni) begin
            pend_q.delete();
            slv_resp = '0;
        end else begin
            if (!manual && hs_valid) pend_q.push_back(hs_addr);
            slv_resp     = '0;
            slv_resp.gnt = slv_gnt;
            if (!manual && slv_used < slv_budget && pend_q.size() > 0) begin
                slv_resp.rvalid = 1'b1;
                slv_resp.rdata  = data_of(pend_q.pop_front());
                slv_used++;
            end
        end
    end

    initial begin
        int k;
        bit found;
        rst_ni          = 1'b0;
        up_req_i        = '0;
        up_req_i.req    = 1'b1;
        man_resp        = '0;
        man_resp.rvalid = 1'b1;
        man_resp.rdata  = 32'h1234_5678;
        slv_gnt         = 1'b0;
        slv_budget      = 0;

        // Reset state, with upstream req and a downstream rvalid applied
        repeat (2) @(negedge clk_i);
        chk("rst_dn_req", 32'(|dn_req_o), 32'd0);
        chk("rst_up_resp", 32'(|up_resp_o), 32'd0);
        chk("rst_outstanding", 32'(outstanding_o), 32'd0);
        cyc();
        up_req_i = '0;
        man_resp = '0;
        rst_ni   = 1'b1;

        // Single read
        cyc();
        up_req_i.req = 1'b1; up_req_i.addr = 32'h1000; up_req_i.be = 4'hF;
        @(negedge clk_i);
        chk("t1_gnt", 32'(up_resp_o.gnt), 32'd1);
        chk("t1_out_c0", 32'(outstanding_o), 32'd0);
        cyc();
        up_req_i = '0; man_resp.gnt = 1'b1;
        @(negedge clk_i);
        chk("t1_dn_req", 32'(dn_req_o.req), 32'd1);
        chk("t1_dn_addr", dn_req_o.addr, 32'h1000);
        chk("t1_out_c1", 32'(outstanding_o), 32'd1);
        cyc();
        man_resp.gnt = 1'b0;
        @(negedge clk_i);
        chk("t1_dn_req_popped", 32'(dn_req_o.req), 32'd0);
        cyc();
        man_resp.rvalid = 1'b1; man_resp.rdata = 32'hDEAD_BEEF;
        @(negedge clk_i);
        chk("t1_rvalid_c3", 32'(up_resp_o.rvalid), 32'(RSP_LAT == 0));
        chk("t1_out_c3", 32'(outstanding_o), 32'd1);
        cyc();
        man_resp = '0;
        @(negedge clk_i);
        chk("t1_rvalid_c4", 32'(up_resp_o.rvalid), 32'(RSP_LAT == 1));
        chk("t1_out_c4", 32'(outstanding_o), 32'(RSP_LAT));
        cyc();
        @(negedge clk_i);
        chk("t1_out_c5", 32'(outstanding_o), 32'd0);
        manual = 1'b0;

        // Backpressure: downstream gnt low, upstream req held high
        slv_gnt = 1'b0; slv_budget = BIG;
        cyc();
        up_req_i.req = 1'b1; up_req_i.be = 4'hF; up_req_i.addr = 32'h3000;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (up_resp_o.gnt) k++;
            if (i == 0) begin
                chk("t2_no_bypass", 32'(dn_req_o.req), 32'd0);
            end else begin
                chk("t2_head_req", 32'(dn_req_o.req), 32'd1);
                chk("t2_head_addr", dn_req_o.addr, 32'h3000);
            end
            cyc();
            up_req_i.addr = 32'h3000 + 32'(k) * 32'h10;
        end
        chk("t2_accepts", 32'(k), 32'd2);
        up_req_i = '0; slv_gnt = 1'b1;
        drain();

        // Outstanding limit: instant grant, no responses
        slv_budget = slv_used;
        cyc();
        up_req_i.req = 1'b1; up_req_i.be = 4'hF; up_req_i.addr = 32'h4000;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (up_resp_o.gnt) k++;
            cyc();
            up_req_i.addr = 32'h4000 + 32'(k) * 32'h10;
        end
        chk("t3_accepts", 32'(k), 32'd4);
        @(negedge clk_i);
        chk("t3_gnt_blocked", 32'(up_resp_o.gnt), 32'd0);
        chk("t3_out_max", 32'(outstanding_o), 32'd4);
        cyc();
        slv_budget = slv_used + 1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk_i);
            if (up_resp_o.rvalid) begin
                found = 1'b1;
                chk("t3_gnt_in_rsp_cycle", 32'(up_resp_o.gnt), 32'd0);
            end
        end
        chk("t3_rsp_seen", 32'(found), 32'd1);
        @(negedge clk_i);
        chk("t3_gnt_back", 32'(up_resp_o.gnt), 32'd1);
        cyc();
        up_req_i = '0; slv_budget = BIG;
        drain();

        // Back-to-back stream of 16 writes
        for (int i = 0; i < 16; i++) begin
            cyc();
            up_req_i.req = 1'b1; up_req_i.we = 1'b1; up_req_i.be = 4'hF;
            up_req_i.addr = 32'h5000 + 32'(i) * 32'd4;
            up_req_i.wdata = 32'hA5A5_0000 + 32'(i);
            @(negedge clk_i);
            chk("t4_gnt", 32'(up_resp_o.gnt), 32'd1);
        end
        cyc();
        up_req_i = '0;
        drain();

        // Push and pop in the same cycle at occupancy 1 for 20 cycles
        for (int i = 0; i < 20; i++) begin
            cyc();
            up_req_i.req = 1'b1; up_req_i.be = 4'h3;
            up_req_i.addr = 32'h6000 + 32'(i) * 32'd4;
            @(negedge clk_i);
            chk("t6_gnt", 32'(up_resp_o.gnt), 32'd1);
            if (i > 0) begin
                chk("t6_occ1", 32'(dn_req_o.req), 32'd1);
                chk("t6_head", dn_req_o.addr, 32'h6000 + 32'(i - 1) * 32'd4);
            end
        end
        cyc();
        up_req_i = '0;
        drain();

        // Reset mid-burst with 2 buffered and 3 outstanding
        slv_budget = slv_used;
        cyc();
        up_req_i.req = 1'b1; up_req_i.be = 4'hF; up_req_i.addr = 32'h7000;
        @(negedge clk_i);
        cyc();
        up_req_i.addr = 32'h7010; slv_gnt = 1'b0;
        @(negedge clk_i);
        cyc();
        up_req_i.addr = 32'h7020;
        @(negedge clk_i);
        cyc();
        up_req_i = '0;
        @(negedge clk_i);
        chk("t5_out_pre", 32'(outstanding_o), 32'd3);
        chk("t5_buffered", 32'(dn_req_o.req), 32'd1);
        #1;
        rst_ni = 1'b0;
        up_req_i.req = 1'b1;
        #1;
        chk("t5_rst_dn", 32'(|dn_req_o), 32'd0);
        chk("t5_rst_up", 32'(|up_resp_o), 32'd0);
        chk("t5_rst_out", 32'(outstanding_o), 32'd0);
        cyc();
        cyc();
        rst_ni = 1'b1;
        up_req_i = '0;
        manual = 1'b1;
        man_resp.rvalid = 1'b1; man_resp.rdata = 32'hBAD0_BAD0;
        @(negedge clk_i);
        chk("t5_stray_c0", 32'(up_resp_o.rvalid), 32'd0);
        cyc();
        man_resp = '0;
        @(negedge clk_i);
        chk("t5_stray_c1", 32'(up_resp_o.rvalid), 32'd0);
        chk("t5_out_post", 32'(outstanding_o), 32'd0);
        manual = 1'b0;

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
